// File: rtl/unary_add_ctrl.sv
// Sequencer around the unary adder: serialises binary operands as unary trains, counts ones back to binary.
// Latency: done pulses in the 8th cycle after the accepting edge (2^(OP_W+1) cycles).
// Backpressure: none; start is sampled only in IDLE and ignored otherwise (no queueing).
module unary_add_ctrl #(
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] a_bin,
  input  logic [OP_W-1:0] b_bin,
  output logic            busy,
  output logic            done,
  output logic [OP_W:0]   sum,
  output logic            A,
  output logic            B,
  output logic            en,
  output logic            read_or_write,
  input  logic            dout,
  input  logic            C
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [OP_W-1:0] READ_LAST  = OP_W'((1 << OP_W) - 2);
  localparam logic [OP_W-1:0] WRITE_LAST = OP_W'((1 << OP_W) - 1);
  localparam logic [OP_W-1:0] IDX_ONE    = OP_W'(1);

  state_t          state, state_nxt;
  logic [OP_W-1:0] idx, idx_nxt;
  logic [OP_W-1:0] ra, ra_nxt;
  logic [OP_W-1:0] rb, rb_nxt;
  logic [OP_W-1:0] ones_cnt, ones_nxt;
  logic            carry_seen, carry_nxt;
  logic [OP_W:0]   sum_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      ra         <= '0;
      rb         <= '0;
      ones_cnt   <= '0;
      carry_seen <= 1'b0;
      sum        <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      ra         <= ra_nxt;
      rb         <= rb_nxt;
      ones_cnt   <= ones_nxt;
      carry_seen <= carry_nxt;
      sum        <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    ra_nxt        = ra;
    rb_nxt        = rb;
    ones_nxt      = ones_cnt;
    carry_nxt     = carry_seen;
    sum_nxt       = sum;
    busy          = 1'b0;
    done          = 1'b0;
    A             = 1'b0;
    B             = 1'b0;
    en            = 1'b0;
    read_or_write = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          ra_nxt    = a_bin;
          rb_nxt    = b_bin;
          ones_nxt  = '0;
          carry_nxt = 1'b0;
          idx_nxt   = '0;
          state_nxt = READ;
        end
      end

      READ: begin
        busy      = 1'b1;
        en        = 1'b1;
        A         = (idx < ra);
        B         = (idx < rb);
        carry_nxt = carry_seen | C;
        idx_nxt   = idx + IDX_ONE;
        if (idx == READ_LAST) begin
          idx_nxt   = '0;
          state_nxt = WRITE;
        end
      end

      WRITE: begin
        busy          = 1'b1;
        en            = 1'b1;
        read_or_write = 1'b1;
        // The last read sample's carry lands here in cycle 0, so keep folding C in.
        carry_nxt     = carry_seen | C;
        if (dout) ones_nxt = ones_cnt + IDX_ONE;
        idx_nxt       = idx + IDX_ONE;
        if (idx == WRITE_LAST) begin
          state_nxt = DONE;
          sum_nxt   = {carry_nxt, ones_nxt};
        end
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Directed bench for unary_add_ctrl with a behavioural 2-bit unary adder model on A/B/dout/C.
module tb_unary_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] a_bin;
  logic [1:0] b_bin;
  logic       busy;
  logic       done;
  logic [2:0] sum;
  logic       A;
  logic       B;
  logic       en;
  logic       read_or_write;
  logic       dout;
  logic       C;

  int n_chk  = 0;
  int n_pass = 0;

  unary_add_ctrl #(.OP_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_bin        (a_bin),
    .b_bin        (b_bin),
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .A            (A),
    .B            (B),
    .en           (en),
    .read_or_write(read_or_write),
    .dout         (dout),
    .C            (C)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder stage: read accumulates A+B mod 4 with registered carry; write drains one unary 1 per cycle.
  logic [1:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 2'd0;
      dout  <= 1'b0;
      C     <= 1'b0;
    end else if (en && !read_or_write) begin
      C     <= (3'(m_cnt) + 3'(A) + 3'(B)) > 3'd3;
      m_cnt <= m_cnt + 2'(A) + 2'(B);
      dout  <= 1'b0;
    end else if (en && read_or_write) begin
      C <= 1'b0;
      if (m_cnt != 2'd0) begin
        dout  <= 1'b1;
        m_cnt <= m_cnt - 2'd1;
      end else begin
        dout <= 1'b0;
      end
    end else begin
      C    <= 1'b0;
      dout <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bit c-1 of each vector holds the sample of cycle c after the accepting edge.
  task automatic do_op(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input bit hold, input bit inj, input logic [2:0] pa, input logic [2:0] pb,
                       input int ones, input int cs, input logic [2:0] exp_sum);
    logic [7:0] a_v, b_v, en_v, rw_v, done_v, busy_v;
    int         n_ones, n_c;
    logic [2:0] s8;
    n_ones = 0;
    n_c    = 0;
    s8     = 3'd0;
    start  = 1'b1;
    a_bin  = a;
    b_bin  = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_v[c]    = A;
      b_v[c]    = B;
      en_v[c]   = en;
      rw_v[c]   = read_or_write;
      done_v[c] = done;
      busy_v[c] = busy;
      if (c >= 3 && c <= 6 && dout) n_ones++;
      if (C) n_c++;
      if (c == 7) s8 = sum;
      if (inj && c == 0) begin
        start = 1'b1;
        a_bin = 2'd3;
        b_bin = 2'd3;
      end
      if (inj && c == 1) start = 1'b0;
    end
    chk({tag, " A"},    32'(a_v),    32'({5'b0, pa}));
    chk({tag, " B"},    32'(b_v),    32'({5'b0, pb}));
    chk({tag, " en"},   32'(en_v),   32'h7f);
    chk({tag, " rw"},   32'(rw_v),   32'h78);
    chk({tag, " done"}, 32'(done_v), 32'h80);
    chk({tag, " busy"}, 32'(busy_v), 32'hff);
    chk({tag, " ones"}, 32'(n_ones), 32'(ones));
    chk({tag, " C"},    32'(n_c),    32'(cs));
    chk({tag, " sum"},  32'(s8),     32'(exp_sum));
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle done"}, 32'(done), 32'd0);
    chk({tag, " sum held"},  32'(sum),  32'(exp_sum));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_bin = 2'd0;
    b_bin = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst outs", 32'({busy, done, sum, A, B, en, read_or_write}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle en", 32'(en), 32'd0);

    do_op("0+0", 2'd0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b000, 0, 0, 3'd0);
    do_op("2+1", 2'd2, 2'd1, 1'b0, 1'b0, 3'b011, 3'b001, 3, 0, 3'd3);
    do_op("2+2", 2'd2, 2'd2, 1'b0, 1'b0, 3'b011, 3'b011, 0, 1, 3'd4);
    // start stays high through DONE; the following op is accepted from IDLE
    do_op("3+3", 2'd3, 2'd3, 1'b1, 1'b0, 3'b111, 3'b111, 2, 1, 3'd6);
    do_op("1+0", 2'd1, 2'd0, 1'b0, 1'b0, 3'b001, 3'b000, 1, 0, 3'd1);
    do_op("inj", 2'd1, 2'd2, 1'b0, 1'b1, 3'b001, 3'b011, 3, 0, 3'd3);

    // Reset in WRITE cycle 2 of 3+2
    start = 1'b1;
    a_bin = 2'd3;
    b_bin = 2'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre-rst phase", 32'({en, read_or_write}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst outs", 32'({busy, done, sum, A, B, en, read_or_write}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst no done", 32'({busy, done, sum}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("1+1", 2'd1, 2'd1, 1'b0, 1'b0, 3'b001, 3'b001, 2, 0, 3'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unary_add_ctrl.md
Name: unary_add_ctrl

Overview:
- Sequencer that sits directly around the 2-bit unary adder stage.
- Takes two binary operands on a start handshake and serialises each as a unary pulse train on the adder's A/B inputs during its read phase.
- Then switches the adder to its write phase, counts the unary 1s returned on dout, folds in the overflow carry C, and presents a binary sum with a one-cycle done pulse.

Parameters:
- OP_W, 2: operand width. Must equal the adder's internal count width. Read phase lasts 2^OP_W-1 cycles, write phase 2^OP_W cycles, sum is OP_W+1 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset; shared with the adder stage
- start  in  1  request; sampled only in IDLE
- a_bin  in  OP_W  operand A, binary, captured on accept
- b_bin  in  OP_W  operand B, binary, captured on accept
- busy  out  1  high from the accept edge until return to IDLE
- done  out  1  one-cycle pulse; sum valid
- sum  out  OP_W+1  binary result, held until the next done
- A  out  1  unary stream to adder
- B  out  1  unary stream to adder
- en  out  1  adder enable
- read_or_write  out  1  0 = adder read phase, 1 = adder write phase
- dout  in  1  unary result stream from adder
- C  in  1  adder carry pulse, registered in the adder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx, ra, rb, ones_cnt, carry_seen cleared.
  - Outputs: busy=0, done=0, sum=0, A=0, B=0, en=0, read_or_write=0.
- Adder-facing outputs A/B/en/read_or_write are decoded only from registered state (Moore). No path from dout/C to outputs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - en=0.
  - On start=1: latch ra=a_bin, rb=b_bin; clear ones_cnt and carry_seen; idx=0; go READ.
  - start in any other state is ignored; no queueing.
- READ (idx = 0 .. 2^OP_W-2):
  - en=1, read_or_write=0, A=(idx<ra), B=(idx<rb).
  - Each edge: idx++, carry_seen |= C.
  - At idx=2^OP_W-2: idx=0, go WRITE.
- WRITE (idx = 0 .. 2^OP_W-1):
  - en=1, read_or_write=1, A=B=0.
  - Each edge: carry_seen |= C; if dout=1 then ones_cnt++; idx++.
  - At idx=2^OP_W-1: go DONE, and register sum = ones_cnt_next + (carry_seen_next ? 2^OP_W : 0).
- DONE:
  - en=0, done=1 for exactly one cycle, busy=1.
  - Next edge: go IDLE.
- Latency: done asserts exactly 2^(OP_W+1) cycles after the accepting edge (OP_W=2: READ 3, WRITE 4, DONE in cycle 8).
- Next start is accepted no earlier than the edge after DONE.
- Write-phase sampling:
  - dout is 0 in WRITE cycle 0 (left over from read phase) and carries up to 2^OP_W-1 ones in cycles 1..3.
  - The 4-cycle write phase drains the adder count to 0, so the adder is clean for the next operation.
- Carry:
  - C is a single-cycle pulse from the adder; carry_seen is sticky for the whole operation.
  - The last read sample's carry appears in WRITE cycle 0 and must be caught.
  - At most one overflow per operation, since max sum = 2·(2^OP_W-1) < 2^(OP_W+1).
- Arithmetic: ones_cnt is OP_W bits and never exceeds 2^OP_W-1. sum is exact for all operand pairs.
- Reset mid-operation: abort immediately to IDLE. No done pulse and sum stays 0. The adder resets on the same rst_n, so no residual count.

Test Plan:
- Reset, then start with a_bin=0, b_bin=0 -> A=B=0 for all 3 READ cycles; dout stays 0; done in cycle 8 with sum=0; carry_seen=0.
- a_bin=2, b_bin=1 -> A pattern 1,1,0 and B pattern 1,0,0 over READ; dout shows three 1s in WRITE cycles 1..3; sum=3; no C pulse.
- a_bin=2, b_bin=2 -> C pulses in READ cycle 2; dout all 0 in WRITE; sum=4.
- a_bin=3, b_bin=3 -> C pulses once; dout shows two 1s; sum=6. Follow immediately with 1+0 (start held high) -> accepted on the edge after DONE; sum=1; carry from the previous operation is not carried over.
- Pulse start during READ with different operands -> ignored; busy stays 1; the result reflects the original operands.
- Assert rst_n=0 in WRITE cycle 2 of a 3+2 operation -> all outputs 0 asynchronously, no done. A new 1+1 afterwards -> sum=2.
